axis_cap_gate: RTL and testbench
================================

AXIS_CAP_GATE -- requirements
Module: axis_cap_gate

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning stream data width in bits (byte count per beat = DATA_W/8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer depth in beats (power of two).
REQ-003 SHALL have ports, clock and reset first:
- axi_aclk  in  1  single clock for all logic
- axi_rst  in  1  synchronous, active-high reset
- s_tdata  in  DATA_W  ADC sample beat
- s_tvalid  in  1  sample valid; source cannot stall
- trigger  in  1  level trigger; rising edge starts capture
- arm  in  1  one-cycle pulse; latches cap_size and arms capture
- abort  in  1  one-cycle pulse; cancels any operation
- cap_size  in  32  capture length in bytes
- m_axis_tdata  out  DATA_W  beat to DMA writer
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  DMA writer ready
- m_axis_tlast  out  1  last beat of capture
- busy  out  1  state is not IDLE
- cap_done  out  1  one-cycle completion pulse
- overflow  out  1  sticky sample-drop flag
- beat_cnt  out  32  beats captured in current or last run

Function
REQ-004 SHALL implement states IDLE, ARMED, CAPTURE, DRAIN.
REQ-005 IDLE->ARMED SHALL occur on arm; latch total = cap_size>>log2(DATA_W/8); ignore the low cap_size bits; clear beat_cnt and overflow.
REQ-006 arm with total==0 SHALL go IDLE->DRAIN directly, so cap_done pulses with zero beats.
REQ-007 ARMED->CAPTURE SHALL occur when trigger=1 and trigger registered one cycle earlier=0; a sample with s_tvalid in that same cycle SHALL be the first captured beat.
REQ-008 In CAPTURE, each s_tvalid with FIFO not full SHALL write the beat to the FIFO and increment beat_cnt.
REQ-009 s_tvalid with FIFO full SHALL drop the beat, not count it, and set overflow until the next arm or reset.
REQ-010 The write of beat number total SHALL move to DRAIN; further samples are ignored.
REQ-011 DRAIN->IDLE SHALL occur once the FIFO is empty and no beat is pending; cap_done pulses in that same cycle.
REQ-012 m_axis SHALL follow AXIS rules: tdata and tlast hold while tvalid=1 and tready=0; transfer occurs on tvalid&tready.
REQ-013 Latency from FIFO write to m_axis_tvalid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-014 A simultaneous FIFO read and write when full SHALL be accepted with no drop.
REQ-015 abort in any state SHALL flush the FIFO, drive m_axis_tvalid=0 next cycle, go to IDLE, not pulse cap_done, and keep beat_cnt.
REQ-016 arm outside IDLE SHALL be ignored; arm and abort in the same cycle: abort wins.
REQ-017 beat_cnt SHALL saturate at 2^32-1.

Reset
REQ-018 axi_rst SHALL force state IDLE, FIFO empty, trigger history 0, and all outputs 0 at the next axi_aclk edge.
REQ-019 axi_rst SHALL take priority over arm, abort and all other inputs.

Configuration
REQ-020 With macro AXIS_CAP_GATE_TLAST_EN defined, m_axis_tlast SHALL be 1 on the beat matching the total-th FIFO write.
REQ-021 Without AXIS_CAP_GATE_TLAST_EN, m_axis_tlast SHALL be constant 0 and the FIFO SHALL store no tlast bit; the downstream writer is length-driven by its commands.

Structure
REQ-022 A shared package axis_cap_pkg SHALL hold the state enum type cap_state_t and localparam BEAT_BYTES = DATA_W/8.
REQ-023 The buffer SHALL be a sub-module sync_fifo_fwft: single clock, synchronous reset, flush input, full/empty outputs, width DATA_W+1.

Verification
REQ-024 Bench SHALL cover: arm cap_size=256, trigger rise, continuous s_tvalid, tready=1 -> exactly 16 beats out, tlast on beat 16 (TLAST_EN), cap_done 1 cycle, beat_cnt=16.
REQ-025 Bench SHALL cover: tready=0 for 40 cycles during a 64-beat capture -> overflow=1, beat_cnt=16, 16 beats delivered in order, no tvalid/tdata change while stalled.
REQ-026 Bench SHALL cover: arm cap_size=8 -> DRAIN then cap_done within 2 cycles, 0 beats out, busy low after.
REQ-027 Bench SHALL cover: abort at beat 5 of 32 with FIFO holding 3 beats -> tvalid=0 next cycle, no cap_done, beat_cnt=5, state IDLE.
REQ-028 Bench SHALL cover: trigger held high across arm -> stays ARMED until trigger falls and rises again.
REQ-029 Bench SHALL cover: axi_rst mid-CAPTURE -> all outputs 0 next cycle, subsequent arm/trigger capture of 4 beats works.

Source files
------------

// File: rtl/axis_cap_pkg.sv
// -----------------------------------------------------------------------------
// axis_cap_pkg
// Shared definitions for the ADC capture gate: the capture FSM state type,
// default geometry and a helper that turns a stream width into the shift that
// converts a byte count into a beat count.
// -----------------------------------------------------------------------------
package axis_cap_pkg;

    localparam int DEFAULT_DATA_W     = 128;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int BEAT_BYTES         = DEFAULT_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } cap_state_t;

    // Right-shift that converts a byte count into whole beats of data_w bits.
    function automatic int beat_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// dout whenever empty is low; rd_en pops it. A write into a full FIFO is
// accepted when a read happens in the same cycle.
//
// Ports:
//   axi_aclk  clock
//   axi_rst   synchronous active-high reset (empties the FIFO)
//   flush     synchronous flush, same effect as reset on the pointers
//   wr_en     write request, din captured if space (or simultaneous read)
//   din       write data
//   rd_en     pop the head entry (ignored when empty)
//   dout      head entry
//   full      no free entries
//   empty     no valid entries
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge axi_aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (axi_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge axi_aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axis_cap_gate.sv
// -----------------------------------------------------------------------------
// axis_cap_gate
// Trigger-gated capture of a non-stallable ADC sample stream into an
// AXI-Stream output for a DMA writer. A one-cycle arm pulse latches the
// capture length; the next rising edge of trigger starts capture; exactly
// cap_size/BEAT_BYTES beats are buffered and forwarded, after which the
// block drains its buffer and pulses cap_done. Samples arriving while the
// buffer is full are dropped and flagged on the sticky overflow output.
//
// Optional feature: define AXIS_CAP_GATE_TLAST_EN to mark the final captured
// beat with m_axis_tlast. Without it tlast is tied low and the buffer does not
// carry a tlast bit.
//
// Ports:
//   axi_aclk       clock
//   axi_rst        synchronous active-high reset
//   s_tdata        ADC sample beat
//   s_tvalid       sample valid (the source cannot be stalled)
//   trigger        level trigger; its rising edge starts capture
//   arm            one-cycle pulse, latches cap_size and arms
//   abort          one-cycle pulse, cancels any operation
//   cap_size       capture length in bytes
//   m_axis_tdata   output beat
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   last beat of capture (feature-dependent)
//   busy           FSM is not idle
//   cap_done       one-cycle completion pulse
//   overflow       sticky sample-drop flag, cleared on arm
//   beat_cnt       beats captured in the current or last run (saturating)
// -----------------------------------------------------------------------------
module axis_cap_gate
    import axis_cap_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              axi_aclk,
    input  logic              axi_rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              trigger,
    input  logic              arm,
    input  logic              abort,
    input  logic [31:0]       cap_size,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              cap_done,
    output logic              overflow,
    output logic [31:0]       beat_cnt
);

    localparam int BEAT_SHIFT = beat_shift(DATA_W);
`ifdef AXIS_CAP_GATE_TLAST_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    cap_state_t        state;
    cap_state_t        state_nxt;
    logic              trig_q;
    logic [31:0]       total;
    logic [31:0]       arm_total;
    logic              trig_rise;
    logic              capturing;
    logic              rd_fire;
    logic              wr_req;
    logic              wr_fire;
    logic              drop;
    logic              last_beat;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        trig_rise = trigger && !trig_q;
        arm_total = cap_size >> BEAT_SHIFT;
        // The cycle in which the trigger rises already captures a valid sample.
        capturing = (state == CAPTURE) || ((state == ARMED) && trig_rise);
        rd_fire   = m_axis_tvalid && m_axis_tready;
        wr_req    = capturing && s_tvalid && !abort;
        // A full buffer still accepts a beat when the head leaves this cycle.
        wr_fire   = wr_req && (!fifo_full || rd_fire);
        drop      = wr_req && !wr_fire;
        last_beat = wr_fire && ((beat_cnt + 32'd1) == total);
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (arm) state_nxt = (arm_total == 32'd0) ? DRAIN : ARMED;
            ARMED:   if (trig_rise) state_nxt = last_beat ? DRAIN : CAPTURE;
            CAPTURE: if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            state    <= IDLE;
            trig_q   <= 1'b0;
            total    <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            trig_q <= trigger;
            if ((state == IDLE) && arm && !abort) begin
                total    <= arm_total;
                beat_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_fire && (beat_cnt != '1)) beat_cnt <= beat_cnt + 32'd1;
                if (drop) overflow <= 1'b1;
            end
        end
    end

`ifdef AXIS_CAP_GATE_TLAST_EN
    assign fifo_din     = {last_beat, s_tdata};
    assign m_axis_tlast = !fifo_empty && fifo_dout[DATA_W];
`else
    assign fifo_din     = s_tdata;
    assign m_axis_tlast = 1'b0;
`endif

    sync_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .axi_aclk (axi_aclk),
        .axi_rst  (axi_rst),
        .flush    (abort),
        .wr_en    (wr_fire),
        .din      (fifo_din),
        .rd_en    (rd_fire),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Data is masked while empty so stale buffer contents never reach the port.
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign busy          = (state != IDLE);
    assign cap_done      = (state == DRAIN) && fifo_empty && !abort;

endmodule

// File: tb/tb_axis_cap_gate.sv
// -----------------------------------------------------------------------------
// tb_axis_cap_gate
// Directed bench for axis_cap_gate with its default parameters (128-bit beats,
// 16-deep buffer). Inputs change 1 ns after the rising edge; outputs are read
// at that point or by the negedge monitor that records accepted beats and
// cap_done pulses.
// -----------------------------------------------------------------------------
module tb_axis_cap_gate;

    localparam int DW = 128;
`ifdef AXIS_CAP_GATE_TLAST_EN
    localparam int TLAST_ON = 1;
`else
    localparam int TLAST_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          trigger;
    logic          arm;
    logic          abort;
    logic [31:0]   cap_size;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          cap_done;
    logic          overflow;
    logic [31:0]   beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] beat_q[$];
    logic          last_q[$];
    int            done_cnt = 0;

    always #5 clk = ~clk;

    axis_cap_gate dut (
        .axi_aclk      (clk),
        .axi_rst       (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .trigger       (trigger),
        .arm           (arm),
        .abort         (abort),
        .cap_size      (cap_size),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .cap_done      (cap_done),
        .overflow      (overflow),
        .beat_cnt      (beat_cnt)
    );

    // Record every beat that transfers at the coming edge, and cap_done pulses.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            beat_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
        end
        if (cap_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_q.delete();
        last_q.delete();
        done_cnt = 0;
    endtask

    task automatic arm_cap(input logic [31:0] size);
        cap_size = size;
        arm      = 1'b1;
        step();
        arm      = 1'b0;
    endtask

    // Drive n consecutive valid samples base, base+1, ...
    task automatic feed(input int n, input int base);
        s_tvalid = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_tdata = DW'(base + i);
            step();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int n, input int base);
        check({tag, "_count"}, DW'(beat_q.size()), DW'(n));
        for (int i = 0; i < n; i++) begin
            if (i < beat_q.size())
                check($sformatf("%s_data%0d", tag, i), beat_q[i], DW'(base + i));
            else
                check($sformatf("%s_data%0d_missing", tag, i), '1, DW'(base + i));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     DW'(busy),     '0);
        check({tag, "_tvalid"},   DW'(m_tvalid), '0);
        check({tag, "_tdata"},    m_tdata,       '0);
        check({tag, "_tlast"},    DW'(m_tlast),  '0);
        check({tag, "_cap_done"}, DW'(cap_done), '0);
        check({tag, "_overflow"}, DW'(overflow), '0);
        check({tag, "_beat_cnt"}, DW'(beat_cnt), '0);
    endtask

    initial begin
        logic [DW-1:0] ref_data;
        bit            have_ref;
        int            stall_bad;
        int            n_last;

        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        trigger  = 1'b0;
        arm      = 1'b0;
        abort    = 1'b0;
        cap_size = '0;
        m_tready = 1'b1;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // 256 bytes -> 16 beats, continuous samples, sink always ready.
        arm_cap(32'd256);
        check("t1_busy_armed", DW'(busy), 1);
        check("t1_cnt_armed", DW'(beat_cnt), 0);
        clear_mon();
        trigger = 1'b1;
        feed(20, 100);
        trigger = 1'b0;
        repeat (3) step();
        check_beats("t1", 16, 100);
        n_last = 0;
        foreach (last_q[i]) if (last_q[i]) n_last++;
        check("t1_tlast_cnt", DW'(n_last), DW'(TLAST_ON));
        check("t1_tlast_b16", DW'(last_q.size() == 16 ? last_q[15] : 1'bx), DW'(TLAST_ON));
        check("t1_done_cnt", DW'(done_cnt), 1);
        check("t1_beat_cnt", DW'(beat_cnt), 16);
        check("t1_busy_after", DW'(busy), 0);
        check("t1_overflow", DW'(overflow), 0);

        // 64-beat capture with the sink stalled for 40 cycles.
        arm_cap(32'd1024);
        clear_mon();
        m_tready  = 1'b0;
        trigger   = 1'b1;
        s_tvalid  = 1'b1;
        have_ref  = 1'b0;
        ref_data  = '0;
        stall_bad = 0;
        for (int i = 0; i < 40; i++) begin
            s_tdata = DW'(1000 + i);
            step();
            if (m_tvalid) begin
                if (!have_ref) begin
                    ref_data = m_tdata;
                    have_ref = 1'b1;
                end else if (m_tdata !== ref_data) begin
                    stall_bad++;
                end
            end else if (have_ref) begin
                stall_bad++;
            end
        end
        s_tvalid = 1'b0;
        trigger  = 1'b0;
        check("t2_first_head", ref_data, DW'(1000));
        check("t2_stall_stable", DW'(stall_bad), 0);
        check("t2_overflow", DW'(overflow), 1);
        check("t2_beat_cnt_stall", DW'(beat_cnt), 16);
        check("t2_no_xfer_stall", DW'(beat_q.size()), 0);
        m_tready = 1'b1;
        repeat (20) step();
        check_beats("t2", 16, 1000);
        check("t2_beat_cnt", DW'(beat_cnt), 16);
        check("t2_still_busy", DW'(busy), 1);
        check("t2_no_done", DW'(done_cnt), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t2_abort_idle", DW'(busy), 0);

        // 8 bytes is less than one beat: straight to completion, no data.
        clear_mon();
        arm_cap(32'd8);
        check("t3_drain_busy", DW'(busy), 1);
        check("t3_cap_done", DW'(cap_done), 1);
        step();
        check("t3_idle", DW'(busy), 0);
        step();
        check("t3_done_cnt", DW'(done_cnt), 1);
        check("t3_beats", DW'(beat_q.size()), 0);
        check("t3_beat_cnt", DW'(beat_cnt), 0);

        // Abort at beat 5 of 32 while the buffer holds 3 beats.
        arm_cap(32'd512);
        clear_mon();
        m_tready = 1'b0;
        trigger  = 1'b1;
        feed(5, 2000);
        trigger  = 1'b0;
        m_tready = 1'b1;
        step();
        step();
        m_tready = 1'b0;
        check("t4_pre_head", m_tdata, DW'(2002));
        check("t4_pre_cnt", DW'(beat_cnt), 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_tvalid", DW'(m_tvalid), 0);
        check("t4_idle", DW'(busy), 0);
        check("t4_beat_cnt", DW'(beat_cnt), 5);
        // arm and abort together in IDLE: abort wins, nothing is cleared.
        cap_size = 32'd256;
        arm      = 1'b1;
        abort    = 1'b1;
        step();
        arm      = 1'b0;
        abort    = 1'b0;
        check("t4_arm_abort_idle", DW'(busy), 0);
        check("t4_arm_abort_cnt", DW'(beat_cnt), 5);
        m_tready = 1'b1;
        repeat (3) step();
        check_beats("t4", 2, 2000);
        check("t4_no_done", DW'(done_cnt), 0);

        // Trigger already high at arm; low bits of cap_size (79 -> 4 beats) ignored.
        m_tready = 1'b1;
        trigger  = 1'b1;
        step();
        arm_cap(32'd79);
        clear_mon();
        feed(5, 3000);
        check("t5_held_armed", DW'(busy), 1);
        check("t5_held_cnt", DW'(beat_cnt), 0);
        check("t5_held_beats", DW'(beat_q.size()), 0);
        trigger = 1'b0;
        feed(1, 3005);
        trigger = 1'b1;
        feed(6, 3010);
        repeat (5) step();
        check_beats("t5", 4, 3010);
        check("t5_done_cnt", DW'(done_cnt), 1);
        check("t5_beat_cnt", DW'(beat_cnt), 4);
        check("t5_idle", DW'(busy), 0);

        // Reset in the middle of a capture, with arm and abort also asserted.
        trigger = 1'b0;
        step();
        arm_cap(32'd512);
        m_tready = 1'b0;
        trigger  = 1'b1;
        feed(6, 4000);
        check("t6_pre_cnt", DW'(beat_cnt), 6);
        rst   = 1'b1;
        arm   = 1'b1;
        abort = 1'b1;
        step();
        check_zero("t6_rst");
        rst      = 1'b0;
        arm      = 1'b0;
        abort    = 1'b0;
        trigger  = 1'b0;
        m_tready = 1'b1;
        step();
        arm_cap(32'd64);
        clear_mon();
        trigger = 1'b1;
        feed(4, 4100);
        trigger = 1'b0;
        repeat (4) step();
        check_beats("t6", 4, 4100);
        check("t6_done_cnt", DW'(done_cnt), 1);
        check("t6_beat_cnt", DW'(beat_cnt), 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
